// File: rtl/sender_pkg.sv
// Shared definitions for the burst memory sender and its 4-phase handshake engine.
package sender_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ADDR_W    = 4;
    localparam int DEF_READY_CYC = 2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_LOAD = 3'd2,
        S_REQ  = 3'd3,
        S_REL  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        HS_IDLE     = 2'd0,
        HS_WAIT_LOW = 2'd1,
        HS_WAIT_ACK = 2'd2
    } hs_phase_t;

endpackage

// File: rtl/sender_burst_if.sv
// Control, memory and receiver-link signals of the burst sender, bundled as one port.
interface sender_burst_if
    import sender_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              transmit;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   length;
    logic              abort;
    logic              read_enable;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              req;
    logic              ack;
    logic              busy;
    logic              ready;
    logic              aborted;
    logic [ADDR_W:0]   word_count;

    modport master (
        input  transmit, start_addr, length, abort, data_in, ack,
        output read_enable, address, data_out, req, busy, ready, aborted, word_count
    );

    modport slave (
        output transmit, start_addr, length, abort, data_in, ack,
        input  read_enable, address, data_out, req, busy, ready, aborted, word_count
    );

endinterface

// File: rtl/hs4_master.sv
// Requester side of a 4-phase Req/Ack handshake; one full cycle per go pulse.
module hs4_master
    import sender_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    input  logic ack,
    output logic done,
    output logic req
);

    hs_phase_t phase;

    // A stale high Ack from the previous word must fall before a new Req is raised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= HS_IDLE;
            req   <= 1'b0;
        end else begin
            case (phase)
                HS_IDLE: begin
                    if (go) begin
                        if (ack) begin
                            phase <= HS_WAIT_LOW;
                        end else begin
                            req   <= 1'b1;
                            phase <= HS_WAIT_ACK;
                        end
                    end
                end
                HS_WAIT_LOW: begin
                    if (!ack) begin
                        req   <= 1'b1;
                        phase <= HS_WAIT_ACK;
                    end
                end
                HS_WAIT_ACK: begin
                    if (ack) begin
                        req   <= 1'b0;
                        phase <= HS_IDLE;
                    end
                end
                default: begin
                    req   <= 1'b0;
                    phase <= HS_IDLE;
                end
            endcase
        end
    end

    // Ack seen while Req is up: the word has been taken by the receiver.
    assign done = (phase == HS_WAIT_ACK) && ack;

endmodule

// File: rtl/sender_burst.sv
// Reads a programmable burst from synchronous memory and sends each word over a 4-phase link.
module sender_burst
    import sender_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int READY_CYC = DEF_READY_CYC
) (
    input  logic           clk,
    input  logic           rst_n,
    sender_burst_if.master bus
);

    localparam int RC_W = (READY_CYC > 1) ? $clog2(READY_CYC) : 1;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   word_count;
    logic [RC_W-1:0]   rdy_cnt;
    logic              abort_pend;
    logic              read_enable;
    logic [DATA_W-1:0] data_out;
    logic              busy;
    logic              ready;
    logic              aborted;

    logic hs_go;
    logic hs_done;
    logic hs_req;

    assign hs_go = (state == S_LOAD);

    hs4_master u_hs (
        .clk  (clk),
        .rst_n(rst_n),
        .go   (hs_go),
        .ack  (bus.ack),
        .done (hs_done),
        .req  (hs_req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            addr        <= '0;
            len         <= '0;
            word_count  <= '0;
            rdy_cnt     <= '0;
            abort_pend  <= 1'b0;
            read_enable <= 1'b0;
            data_out    <= '0;
            busy        <= 1'b0;
            ready       <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            if (state != S_IDLE && bus.abort) begin
                abort_pend <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (bus.transmit) begin
                        addr       <= bus.start_addr;
                        len        <= bus.length;
                        word_count <= '0;
                        aborted    <= 1'b0;
                        abort_pend <= 1'b0;
                        busy       <= 1'b1;
                        if (bus.length == '0) begin
                            ready   <= 1'b1;
                            rdy_cnt <= RC_W'(READY_CYC - 1);
                            state   <= S_DONE;
                        end else begin
                            read_enable <= 1'b1;
                            state       <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    read_enable <= 1'b0;
                    state       <= S_LOAD;
                end
                S_LOAD: begin
                    data_out <= bus.data_in;
                    state    <= S_REQ;
                end
                S_REQ: begin
                    if (hs_done) begin
                        word_count <= word_count + 1'b1;
                        state      <= S_REL;
                    end
                end
                S_REL: begin
                    // Reaching Length wins over a pending abort, so Aborted marks only truncated bursts.
                    if (!bus.ack) begin
                        if (word_count == len) begin
                            ready   <= 1'b1;
                            rdy_cnt <= RC_W'(READY_CYC - 1);
                            state   <= S_DONE;
                        end else if (abort_pend || bus.abort) begin
                            ready   <= 1'b1;
                            aborted <= 1'b1;
                            rdy_cnt <= RC_W'(READY_CYC - 1);
                            state   <= S_DONE;
                        end else begin
                            addr        <= addr + 1'b1;
                            read_enable <= 1'b1;
                            state       <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    if (rdy_cnt == '0) begin
                        ready <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        rdy_cnt <= rdy_cnt - 1'b1;
                    end
                end
                default: begin
                    read_enable <= 1'b0;
                    ready       <= 1'b0;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.read_enable = read_enable;
    assign bus.address     = addr;
    assign bus.data_out    = data_out;
    assign bus.req         = hs_req;
    assign bus.busy        = busy;
    assign bus.ready       = ready;
    assign bus.aborted     = aborted;
    assign bus.word_count  = word_count;

endmodule

// File: tb/tb_sender_burst.sv
// Scoreboard bench for sender_burst: directed scenarios plus randomized bursts with a responder.
module tb_sender_burst;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 4;
    localparam int READY_CYC = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sender_burst_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sender_burst #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READY_CYC(READY_CYC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } word_t;

    typedef struct {
        int wc;
        bit ab;
        int reads;
    } done_t;

    word_t exp_words[$];
    done_t exp_done[$];

    int n_vec  = 0;
    int n_fail = 0;

    bit ack_force = 1'b0;
    bit rand_lat  = 1'b0;
    int ack_lat   = 1;
    int rel_lat   = 1;

    logic [DATA_W-1:0] mem [1 << ADDR_W];
    logic [ADDR_W-1:0] rd_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_vec++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req_v, $time);
        end
    endtask

    // Synchronous memory: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.read_enable) begin
            bus.data_in <= mem[bus.address];
            rd_addr     <= bus.address;
        end
    end

    // Receiver: raise Ack some cycles after Req, drop it some cycles after Req falls.
    initial begin
        int cnt;
        cnt     = 0;
        bus.ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                bus.ack = 1'b0;
                cnt     = 0;
            end else if (ack_force) begin
                bus.ack = 1'b1;
            end else if (!bus.ack) begin
                if (bus.req) begin
                    if (cnt >= ack_lat) begin bus.ack = 1'b1; cnt = 0; end
                    else cnt++;
                end else begin
                    cnt = 0;
                end
            end else if (!bus.req) begin
                if (cnt >= rel_lat) begin
                    bus.ack = 1'b0;
                    cnt     = 0;
                    if (rand_lat) begin
                        ack_lat = $urandom_range(0, 3);
                        rel_lat = $urandom_range(0, 2);
                    end
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever a word is offered or a burst finishes.
    initial begin
        logic req_q, rdy_q;
        logic [DATA_W-1:0] held;
        int rdy_len, rd_cnt;
        word_t w;
        done_t d;
        req_q = 1'b0; rdy_q = 1'b0; held = '0; rdy_len = 0; rd_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                req_q = 1'b0; rdy_q = 1'b0; rdy_len = 0; rd_cnt = 0;
            end else begin
                if (bus.read_enable) rd_cnt++;
                if (bus.req && !req_q) begin
                    if (exp_words.size() == 0) begin
                        check("spurious_req", 1, 0);
                    end else begin
                        w = exp_words.pop_front();
                        check("word_data", bus.data_out, w.data);
                        check("word_addr", rd_addr, w.addr);
                        held = bus.data_out;
                    end
                end else if (bus.req) begin
                    check("data_stable", bus.data_out, held);
                end
                if (bus.ready && !rdy_q) begin
                    if (exp_done.size() == 0) begin
                        check("spurious_ready", 1, 0);
                    end else begin
                        d = exp_done.pop_front();
                        check("word_count", bus.word_count, d.wc);
                        check("aborted", bus.aborted, d.ab);
                        check("read_count", rd_cnt, d.reads);
                        check("busy_at_ready", bus.busy, 1);
                    end
                    rdy_len = 0;
                end
                if (bus.ready) begin
                    rdy_len++;
                end else if (rdy_q) begin
                    check("ready_len", rdy_len, READY_CYC);
                    check("busy_after_ready", bus.busy, 0);
                    rd_cnt = 0;
                end
                req_q = bus.req;
                rdy_q = bus.ready;
            end
        end
    end

    // Reference: the words a burst must emit and how it must end.
    task automatic push_burst(input int sa, input int ln, input int abort_at, output int n, output bit ab);
        logic [ADDR_W-1:0] a;
        ab = (abort_at > 0) && (abort_at < ln);
        n  = ab ? abort_at : ln;
        for (int i = 0; i < n; i++) begin
            a = ADDR_W'((sa + i) % (1 << ADDR_W));
            exp_words.push_back('{addr: a, data: mem[a]});
        end
        exp_done.push_back('{wc: n, ab: ab, reads: n});
    endtask

    task automatic kick(input int sa, input int ln);
        bus.start_addr = ADDR_W'(sa);
        bus.length     = (ADDR_W + 1)'(ln);
        bus.transmit   = 1'b1;
        @(posedge clk); #1;
        bus.transmit   = 1'b0;
    endtask

    // Runs until Ready falls; optionally pulses Abort or a stray Transmit at a given word.
    task automatic wait_burst(input int abort_at, input int extra_tx_at);
        int  words;
        bit  prev, rdy_seen;
        words = 0; prev = bus.req; rdy_seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            bus.abort = 1'b0;
            if (extra_tx_at > 0) bus.transmit = 1'b0;
            if (bus.req && !prev) begin
                words++;
                if (words == abort_at) bus.abort = 1'b1;
                if (words == extra_tx_at) begin
                    bus.transmit   = 1'b1;
                    bus.start_addr = ADDR_W'($urandom_range(0, 15));
                    bus.length     = (ADDR_W + 1)'($urandom_range(1, 16));
                end
            end
            prev = bus.req;
            if (bus.ready) rdy_seen = 1'b1;
            else if (rdy_seen) return;
        end
        check("burst_timeout", 0, 1);
    endtask

    task automatic check_hold(input int n, input bit ab);
        check("wc_hold", bus.word_count, n);
        check("aborted_hold", bus.aborted, ab);
    endtask

    initial begin
        int n, n2, sa, ln, ab_at, w;
        bit ab, ab2, prev;
        bus.transmit = 1'b0; bus.start_addr = '0; bus.length = '0; bus.abort = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'hA000 + 16'(i);

        repeat (3) @(posedge clk);
        #1;
        check("rst_read_enable", bus.read_enable, 0);
        check("rst_address", bus.address, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_req", bus.req, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.ready, 0);
        check("rst_aborted", bus.aborted, 0);
        check("rst_word_count", bus.word_count, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full 16-word burst, Ack two cycles after Req.
        ack_lat = 2; rel_lat = 1;
        push_burst(0, 16, 0, n, ab);
        kick(0, 16);
        wait_burst(0, 0);
        check_hold(n, ab);

        // Address wrap 14,15,0,1.
        push_burst(14, 4, 0, n, ab);
        kick(14, 4);
        wait_burst(0, 0);
        check_hold(n, ab);

        // Length 0: straight to Ready.
        push_burst(7, 0, 0, n, ab);
        kick(7, 0);
        check("len0_ready", bus.ready, 1);
        check("len0_busy", bus.busy, 1);
        wait_burst(0, 0);
        check_hold(n, ab);

        // Abort during word 3 of 10.
        push_burst(2, 10, 3, n, ab);
        kick(2, 10);
        wait_burst(3, 0);
        check_hold(n, ab);

        // Ack stuck high at Transmit, then a Transmit while busy.
        ack_force = 1'b1; ack_lat = 1; rel_lat = 0;
        @(posedge clk); #1;
        push_burst(3, 2, 0, n, ab);
        kick(3, 2);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("req_held_low", bus.req, 0);
        end
        ack_force = 1'b0;
        wait_burst(0, 1);
        check_hold(n, ab);

        // Transmit held across DONE->IDLE starts the next burst.
        push_burst(5, 3, 0, n, ab);
        push_burst(12, 6, 0, n2, ab2);
        bus.start_addr = 4'd5; bus.length = 5'd3; bus.transmit = 1'b1;
        @(posedge clk); #1;
        bus.start_addr = 4'd12; bus.length = 5'd6;
        wait_burst(0, 0);
        check("held_idle_busy", bus.busy, 0);
        check_hold(n, ab);
        for (int c = 0; c < 10 && !bus.busy; c++) begin
            @(posedge clk); #1;
        end
        check("held_restart", bus.busy, 1);
        bus.transmit = 1'b0;
        wait_burst(0, 0);
        check_hold(n2, ab2);

        // Reset during word 5 of a 16-word burst.
        push_burst(0, 16, 0, n, ab);
        kick(0, 16);
        w = 0; prev = 1'b0;
        for (int c = 0; c < 400 && w < 5; c++) begin
            @(posedge clk); #1;
            if (bus.req && !prev) w++;
            prev = bus.req;
        end
        check("reached_word5", w, 5);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_req", bus.req, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_word_count", bus.word_count, 0);
        check("mid_rst_read_enable", bus.read_enable, 0);
        check("mid_rst_ready", bus.ready, 0);
        exp_words.delete();
        exp_done.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_no_read", bus.read_enable, 0);
        push_burst(9, 5, 0, n, ab);
        kick(9, 5);
        wait_burst(0, 0);
        check_hold(n, ab);

        // Randomized bursts.
        rand_lat = 1'b1;
        for (int b = 0; b < 12; b++) begin
            for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom);
            sa    = $urandom_range(0, 15);
            ln    = $urandom_range(0, 16);
            ab_at = ($urandom_range(0, 2) == 0 && ln > 0) ? $urandom_range(1, ln) : 0;
            push_burst(sa, ln, ab_at, n, ab);
            kick(sa, ln);
            wait_burst(ab_at, 0);
            check_hold(n, ab);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (4) @(posedge clk);
        check("leftover_words", exp_words.size(), 0);
        check("leftover_done", exp_done.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "bench timeout");
    end

endmodule
